// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and backing data memory.
// Stores are queued in a small circular FIFO and drained in order through a
// two-state request/ack handshake. Loads get data forwarded from the youngest
// matching buffered store; otherwise the backing-memory read data passes through.
module dmem_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              aluout,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  output logic [31:0]              mem_raddr,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t         state;
  logic [29:0]    tag_q  [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [AW-1:0]  head_next;
  logic [AW-1:0]  fwd_idx;
  logic [CW-1:0]  count_next;
  logic           push;
  logic           pop;

  // Handshake qualifiers: a held store never enters, an ack outside REQ is ignored
  assign stall      = (count == CW'(DEPTH));
  assign push       = memwrite & ~stall;
  assign pop        = (state == REQ) & mem_ack;
  assign count_next = count + CW'(push) - CW'(pop);
  assign head_next  = head + AW'(1);
  assign mem_raddr  = aluout & 32'hFFFF_FFFC;

  // Entry storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail]  <= aluout[31:2];
      data_q[tail] <= writedata;
    end
  end

  // Pointers, occupancy and drain FSM with registered memory-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      count <= count_next;
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head_next;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= REQ;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_q[head], 2'b00};
            mem_wdata <= data_q[head];
          end
        end
        REQ: begin
          if (pop) begin
            if (count_next == '0) begin
              state     <= IDLE;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
            end else if (count == CW'(1)) begin
              // Only the store being pushed this edge remains: take it from the inputs
              mem_addr  <= {aluout[31:2], 2'b00};
              mem_wdata <= writedata;
            end else begin
              mem_addr  <= {tag_q[head_next], 2'b00};
              mem_wdata <= data_q[head_next];
            end
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Load forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    readdata = mem_rdata;
    fwd_idx  = head;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = head + AW'(i);
      if ((CW'(i) < count) && (tag_q[fwd_idx] == aluout[31:2])) begin
        readdata = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer: vector table plus corner-case
// sequences, with a scoreboard tracking accepted stores against drained writes.
module tb_dmem_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          memwrite;
  logic [31:0]   aluout;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          stall;
  logic [CW-1:0] count;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_raddr;
  logic [31:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sbq[$];

  typedef struct {
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic [3:0]  cnt;
    logic        stl;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[20];

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .stall(stall), .count(count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rd);
    memwrite  = mw;
    aluout    = a;
    writedata = wd;
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    while ((count != '0 || mem_we) && n < 20) begin
      step();
      n++;
    end
    chk({name, "_count"}, 32'(count), 32'd0);
    chk({name, "_we"}, 32'(mem_we), 32'd0);
    chk({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
  endtask

  // Scoreboard: record stores that will be accepted and drains that will complete at the next edge
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we && mem_ack) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", {mem_addr[31:2], 2'b00}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_addr", mem_addr, sbq[0][63:32]);
          chk("sb_wdata", mem_wdata, sbq[0][31:0]);
          void'(sbq.pop_front());
        end
      end
      if (memwrite && !stall) sbq.push_back({aluout & 32'hFFFF_FFFC, writedata});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // single store with ack tied high
    tbl[0]  = '{1'b1, 32'h54, 32'h12344321, 1'b1, 32'h0,        4'd1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h12344321};
    tbl[1]  = '{1'b0, 32'h54, 32'h0,        1'b1, 32'h0,        4'd1, 1'b0, 1'b1, 32'h54, 32'h12344321, 32'h12344321};
    tbl[2]  = '{1'b0, 32'h54, 32'h0,        1'b1, 32'hCAFE0000, 4'd0, 1'b0, 1'b0, 32'h0,  32'h0,        32'hCAFE0000};
    // fill to full, hold a fifth store, then pulse ack
    tbl[3]  = '{1'b1, 32'h0,  32'h100, 1'b0, 32'h5A5A5A5A, 4'd1, 1'b0, 1'b0, 32'h0,  32'h0,   32'h100};
    tbl[4]  = '{1'b1, 32'h4,  32'h104, 1'b0, 32'h5A5A5A5A, 4'd2, 1'b0, 1'b1, 32'h0,  32'h100, 32'h104};
    tbl[5]  = '{1'b1, 32'h8,  32'h108, 1'b0, 32'h5A5A5A5A, 4'd3, 1'b0, 1'b1, 32'h0,  32'h100, 32'h108};
    tbl[6]  = '{1'b1, 32'hC,  32'h10C, 1'b0, 32'h5A5A5A5A, 4'd4, 1'b1, 1'b1, 32'h0,  32'h100, 32'h10C};
    tbl[7]  = '{1'b1, 32'h10, 32'h110, 1'b0, 32'h5A5A5A5A, 4'd4, 1'b1, 1'b1, 32'h0,  32'h100, 32'h5A5A5A5A};
    tbl[8]  = '{1'b1, 32'h10, 32'h110, 1'b1, 32'h5A5A5A5A, 4'd3, 1'b0, 1'b1, 32'h4,  32'h104, 32'h5A5A5A5A};
    tbl[9]  = '{1'b1, 32'h10, 32'h110, 1'b0, 32'h5A5A5A5A, 4'd4, 1'b1, 1'b1, 32'h4,  32'h104, 32'h110};
    tbl[10] = '{1'b0, 32'h0,  32'h0,   1'b1, 32'h5A5A5A5A, 4'd3, 1'b0, 1'b1, 32'h8,  32'h108, 32'h5A5A5A5A};
    tbl[11] = '{1'b0, 32'h0,  32'h0,   1'b1, 32'h5A5A5A5A, 4'd2, 1'b0, 1'b1, 32'hC,  32'h10C, 32'h5A5A5A5A};
    tbl[12] = '{1'b0, 32'h0,  32'h0,   1'b1, 32'h5A5A5A5A, 4'd1, 1'b0, 1'b1, 32'h10, 32'h110, 32'h5A5A5A5A};
    tbl[13] = '{1'b0, 32'h0,  32'h0,   1'b1, 32'h5A5A5A5A, 4'd0, 1'b0, 1'b0, 32'h0,  32'h0,   32'h5A5A5A5A};
    // forwarding of the youngest matching store
    tbl[14] = '{1'b1, 32'h20, 32'hAAAA0001, 1'b0, 32'hDEADBEEF, 4'd1, 1'b0, 1'b0, 32'h0,  32'h0,        32'hAAAA0001};
    tbl[15] = '{1'b1, 32'h20, 32'hBBBB0002, 1'b0, 32'hDEADBEEF, 4'd2, 1'b0, 1'b1, 32'h20, 32'hAAAA0001, 32'hBBBB0002};
    tbl[16] = '{1'b0, 32'h22, 32'h0,        1'b0, 32'hDEADBEEF, 4'd2, 1'b0, 1'b1, 32'h20, 32'hAAAA0001, 32'hBBBB0002};
    tbl[17] = '{1'b0, 32'h24, 32'h0,        1'b0, 32'hDEADBEEF, 4'd2, 1'b0, 1'b1, 32'h20, 32'hAAAA0001, 32'hDEADBEEF};
    tbl[18] = '{1'b0, 32'h20, 32'h0,        1'b1, 32'hDEADBEEF, 4'd1, 1'b0, 1'b1, 32'h20, 32'hBBBB0002, 32'hBBBB0002};
    tbl[19] = '{1'b0, 32'h20, 32'h0,        1'b1, 32'hDEADBEEF, 4'd0, 1'b0, 1'b0, 32'h0,  32'h0,        32'hDEADBEEF};

    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].mw, tbl[i].a, tbl[i].wd, tbl[i].ack, tbl[i].rd);
      step();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].stl));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wdata);
      chk($sformatf("v%0d_readdata", i), readdata, tbl[i].rdat);
      chk($sformatf("v%0d_raddr", i), mem_raddr, tbl[i].a & 32'hFFFF_FFFC);
    end

    // simultaneous push and pop at count 2, then at count 1 (pushed entry becomes head)
    drive(1'b1, 32'h40, 32'h1040, 1'b0, 32'h0BAD0BAD);
    step();
    drive(1'b1, 32'h44, 32'h1044, 1'b0, 32'h0BAD0BAD);
    step();
    chk("pp_pre_count", 32'(count), 32'd2);
    drive(1'b1, 32'h48, 32'h1048, 1'b1, 32'h0BAD0BAD);
    #1;
    chk("fwd_excludes_push", readdata, 32'h0BAD0BAD);
    step();
    chk("pp2_count", 32'(count), 32'd2);
    chk("pp2_addr", mem_addr, 32'h44);
    chk("pp2_wdata", mem_wdata, 32'h1044);
    drive(1'b0, 32'h44, 32'h0, 1'b1, 32'h0BAD0BAD);
    #1;
    chk("fwd_head_acked", readdata, 32'h1044);
    step();
    chk("pp_pop_addr", mem_addr, 32'h48);
    drive(1'b1, 32'h4C, 32'h104C, 1'b1, 32'h0BAD0BAD);
    step();
    chk("pp1_count", 32'(count), 32'd1);
    chk("pp1_we", 32'(mem_we), 32'd1);
    chk("pp1_addr", mem_addr, 32'h4C);
    chk("pp1_wdata", mem_wdata, 32'h104C);
    drain("pp_drain");

    // continuous push with ack tied high: order is checked by the scoreboard
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b1, 32'h0);
      step();
      chk($sformatf("wrap%0d_count_le_depth", i), 32'(count <= CW'(DEPTH)), 32'd1);
    end
    drain("wrap_drain");

    // reset while a drain request is outstanding
    drive(1'b1, 32'h200, 32'hA200, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h204, 32'hA204, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h208, 32'hA208, 1'b0, 32'h0);
    step();
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_we", 32'(mem_we), 32'd1);
    drive(1'b0, 32'h204, 32'h0, 1'b1, 32'h77);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_wdata", mem_wdata, 32'h0);
    sbq.delete();
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 32'h204, 32'h0, 1'b1, 32'h77);
    #1;
    chk("post_rst_load", readdata, 32'h77);
    step();
    chk("idle_ack_ignored_we", 32'(mem_we), 32'd0);
    chk("idle_ack_ignored_count", 32'(count), 32'd0);
    drive(1'b1, 32'h300, 32'h3300, 1'b0, 32'h77);
    step();
    chk("post_rst_push_count", 32'(count), 32'd1);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
